cmp_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 16-bit signed less-than block. Sits in the execute stage and produces the WISC set-on-condition results: SEQ, SLT, SLE and SCO.
- Supports signed or unsigned compare, any even WIDTH, and a 2-stage split-half pipeline with valid/ready backpressure.
- Carries a tag through the pipeline so the issuing logic can match each result to its instruction.

---
 rtl/cmp_unit_pipe.sv | 120 ++++++++++++
 tb/tb_cmp_unit_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_unit_pipe.sv
// Two-stage split-half compare (SEQ/SLT/SLE/SCO) with a pass-through tag; result 2 cycles after accept.
// Valid/ready backpressure: holds up to two ops, in_ready drops only when both stages are full and out_ready=0.
module cmp_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_flag,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {
    OpSeq = 2'b00,
    OpSlt = 2'b01,
    OpSle = 2'b10,
    OpSco = 2'b11
  } op_e;

  typedef struct packed {
    logic             hiEq;
    logic             hiLt;
    logic             loEq;
    logic             loLt;
    logic             cLo;
    logic             gHi;
    logic             pHi;
    op_e              op;
    logic [TAG_W-1:0] tag;
  } s1Data_t;

  logic [HALF-1:0] aHi, aLo, bHi, bLo;
  logic [HALF:0]   loSum, hiSum;
  s1Data_t         s1Next, s1Data;
  logic            s1Valid, s2Valid;
  logic            s1Adv, s2Adv;
  logic            eq, lt, co, flagNext;

  assign aHi   = in_a[WIDTH-1:HALF];
  assign aLo   = in_a[HALF-1:0];
  assign bHi   = in_b[WIDTH-1:HALF];
  assign bLo   = in_b[HALF-1:0];
  assign loSum = {1'b0, aLo} + {1'b0, bLo};
  assign hiSum = {1'b0, aHi} + {1'b0, bHi};

  assign s2Adv    = !s2Valid || out_ready;
  assign s1Adv    = !s1Valid || s2Adv;
  assign in_ready = s1Adv;

  // Only the upper slice carries the sign; the low slice is always an unsigned magnitude.
  always_comb begin
    s1Next      = '0;
    s1Next.hiEq = (aHi == bHi);
    if (in_signed) begin
      s1Next.hiLt = ($signed(aHi) < $signed(bHi));
    end else begin
      s1Next.hiLt = (aHi < bHi);
    end
    s1Next.loEq = (aLo == bLo);
    s1Next.loLt = (aLo < bLo);
    s1Next.cLo  = loSum[HALF];
    s1Next.gHi  = hiSum[HALF];
    s1Next.pHi  = &hiSum[HALF-1:0];
    s1Next.op   = op_e'(in_op);
    s1Next.tag  = in_tag;
  end

  assign eq = s1Data.hiEq & s1Data.loEq;
  assign lt = s1Data.hiLt | (s1Data.hiEq & s1Data.loLt);
  assign co = s1Data.gHi | (s1Data.pHi & s1Data.cLo);

  always_comb begin
    flagNext = 1'b0;
    case (s1Data.op)
      OpSeq:   flagNext = eq;
      OpSlt:   flagNext = lt;
      OpSle:   flagNext = lt | eq;
      OpSco:   flagNext = co;
      default: flagNext = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Data  <= '0;
    end else if (s1Adv) begin
      s1Valid <= in_valid;
      s1Data  <= s1Next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid  <= 1'b0;
      out_flag <= 1'b0;
      out_tag  <= '0;
    end else if (s2Adv) begin
      s2Valid  <= s1Valid;
      out_flag <= flagNext;
      out_tag  <= s1Data.tag;
    end
  end

  assign out_valid  = s2Valid;
  assign out_result = {{(WIDTH-1){1'b0}}, out_flag};

endmodule

// File: tb/tb_cmp_unit_pipe.sv
// Directed bench for cmp_unit_pipe at WIDTH 8, 16 and 32 plus streaming, stall and reset sequences.
module tb_cmp_unit_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld8 = 1'b0, vld16 = 1'b0, vld32 = 1'b0;
  logic        outRdy = 1'b1;
  logic [1:0]  opR = 2'b00;
  logic        sgnR = 1'b0;
  logic [31:0] aR = '0, bR = '0;
  logic [3:0]  tagR = '0;

  logic        ir8, ov8, fl8;
  logic [7:0]  res8;
  logic [3:0]  tag8;
  logic        ir16, ov16, fl16;
  logic [15:0] res16;
  logic [3:0]  tag16;
  logic        ir32, ov32, fl32;
  logic [31:0] res32;
  logic [3:0]  tag32;

  int nVec = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  cmp_unit_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(vld8), .in_ready(ir8), .in_a(aR[7:0]), .in_b(bR[7:0]),
    .in_op(opR), .in_signed(sgnR), .in_tag(tagR), .out_valid(ov8), .out_ready(outRdy),
    .out_flag(fl8), .out_result(res8), .out_tag(tag8));

  cmp_unit_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(vld16), .in_ready(ir16), .in_a(aR[15:0]), .in_b(bR[15:0]),
    .in_op(opR), .in_signed(sgnR), .in_tag(tagR), .out_valid(ov16), .out_ready(outRdy),
    .out_flag(fl16), .out_result(res16), .out_tag(tag16));

  cmp_unit_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(vld32), .in_ready(ir32), .in_a(aR), .in_b(bR),
    .in_op(opR), .in_signed(sgnR), .in_tag(tagR), .out_valid(ov32), .out_ready(outRdy),
    .out_flag(fl32), .out_result(res32), .out_tag(tag32));

  typedef struct {
    int          w;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  localparam logic [1:0] SEQ = 2'b00, SLT = 2'b01, SLE = 2'b10, SCO = 2'b11;

  vec_t vecs[34];

  function automatic logic getIr(input int w);
    return (w == 8) ? ir8 : (w == 32) ? ir32 : ir16;
  endfunction

  function automatic logic getOv(input int w);
    return (w == 8) ? ov8 : (w == 32) ? ov32 : ov16;
  endfunction

  function automatic logic getFl(input int w);
    return (w == 8) ? fl8 : (w == 32) ? fl32 : fl16;
  endfunction

  function automatic logic [31:0] getRes(input int w);
    return (w == 8) ? {24'b0, res8} : (w == 32) ? res32 : {16'b0, res16};
  endfunction

  function automatic logic [3:0] getTag(input int w);
    return (w == 8) ? tag8 : (w == 32) ? tag32 : tag16;
  endfunction

  task automatic setVld(input int w, input logic v);
    vld8  = (w == 8)  && v;
    vld16 = (w == 16) && v;
    vld32 = (w == 32) && v;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; accept happens on the next rising edge.
  task automatic runVec(input int w, input logic [1:0] op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic exp, input logic [3:0] tag, input string nm);
    @(negedge clk);
    chk({nm, " in_ready"}, {31'b0, getIr(w)}, 32'd1);
    opR = op; sgnR = sgn; aR = a; bR = b; tagR = tag;
    setVld(w, 1'b1);
    @(negedge clk);
    setVld(w, 1'b0);
    chk({nm, " early_valid"}, {31'b0, getOv(w)}, 32'd0);
    @(negedge clk);
    chk({nm, " out_valid"}, {31'b0, getOv(w)}, 32'd1);
    chk({nm, " out_flag"}, {31'b0, getFl(w)}, {31'b0, exp});
    chk({nm, " out_result"}, getRes(w), {31'b0, exp});
    chk({nm, " out_tag"}, {28'b0, getTag(w)}, {28'b0, tag});
  endtask

  initial begin
    vecs[0]  = '{16, SLT, 1'b1, 32'h8000, 32'h7FFF, 1'b1};
    vecs[1]  = '{16, SLT, 1'b0, 32'h8000, 32'h7FFF, 1'b0};
    vecs[2]  = '{16, SLT, 1'b0, 32'h12FF, 32'h1300, 1'b1};
    vecs[3]  = '{16, SEQ, 1'b0, 32'hA5A5, 32'hA5A5, 1'b1};
    vecs[4]  = '{16, SLE, 1'b1, 32'hFFFD, 32'hFFFC, 1'b0};
    vecs[5]  = '{16, SLE, 1'b0, 32'h000A, 32'h000A, 1'b1};
    vecs[6]  = '{16, SCO, 1'b0, 32'hFFFF, 32'h0001, 1'b1};
    vecs[7]  = '{16, SCO, 1'b0, 32'h00FF, 32'h0001, 1'b0};
    vecs[8]  = '{16, SCO, 1'b1, 32'h80FF, 32'h7F01, 1'b1};
    vecs[9]  = '{16, SCO, 1'b0, 32'h8000, 32'h7FFF, 1'b0};
    vecs[10] = '{16, SEQ, 1'b0, 32'h1234, 32'h1235, 1'b0};
    vecs[11] = '{16, SLT, 1'b1, 32'hFF01, 32'hFF80, 1'b1};
    vecs[12] = '{16, SLT, 1'b1, 32'h7FFF, 32'h8000, 1'b0};
    vecs[13] = '{16, SLT, 1'b1, 32'h000A, 32'h000A, 1'b0};
    vecs[14] = '{8,  SLT, 1'b1, 32'h80, 32'h7F, 1'b1};
    vecs[15] = '{8,  SLT, 1'b0, 32'h80, 32'h7F, 1'b0};
    vecs[16] = '{8,  SLT, 1'b0, 32'h1F, 32'h20, 1'b1};
    vecs[17] = '{8,  SEQ, 1'b0, 32'hA5, 32'hA5, 1'b1};
    vecs[18] = '{8,  SLE, 1'b1, 32'hFD, 32'hFC, 1'b0};
    vecs[19] = '{8,  SLE, 1'b0, 32'h0A, 32'h0A, 1'b1};
    vecs[20] = '{8,  SCO, 1'b0, 32'hFF, 32'h01, 1'b1};
    vecs[21] = '{8,  SCO, 1'b0, 32'h0F, 32'h01, 1'b0};
    vecs[22] = '{8,  SCO, 1'b0, 32'h8F, 32'h71, 1'b1};
    vecs[23] = '{8,  SCO, 1'b0, 32'h80, 32'h7F, 1'b0};
    vecs[24] = '{32, SLT, 1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b1};
    vecs[25] = '{32, SLT, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0};
    vecs[26] = '{32, SLT, 1'b0, 32'h1234FFFF, 32'h12350000, 1'b1};
    vecs[27] = '{32, SEQ, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1};
    vecs[28] = '{32, SLE, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFC, 1'b0};
    vecs[29] = '{32, SLE, 1'b0, 32'h0000000A, 32'h0000000A, 1'b1};
    vecs[30] = '{32, SCO, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1};
    vecs[31] = '{32, SCO, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0};
    vecs[32] = '{32, SCO, 1'b0, 32'h8000FFFF, 32'h7FFF0001, 1'b1};
    vecs[33] = '{32, SCO, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0};

    // Reset state of every instance
    #12;
    for (int w = 8; w <= 32; w = w * 2) begin
      chk($sformatf("rst_in_ready_w%0d", w), {31'b0, getIr(w)}, 32'd1);
      chk($sformatf("rst_out_valid_w%0d", w), {31'b0, getOv(w)}, 32'd0);
      chk($sformatf("rst_out_result_w%0d", w), getRes(w), 32'd0);
      chk($sformatf("rst_out_tag_w%0d", w), {28'b0, getTag(w)}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 34; i++) begin
      runVec(vecs[i].w, vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp,
             4'(i), $sformatf("vec%0d_w%0d", i, vecs[i].w));
    end

    // Streaming: tags 0..7 back-to-back, results on consecutive cycles
    @(negedge clk);
    opR = SEQ; sgnR = 1'b0; aR = 32'h5555; bR = 32'h5555;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 2) begin
        chk($sformatf("stream_valid_c%0d", c), {31'b0, ov16}, 32'd1);
        chk($sformatf("stream_tag_c%0d", c), {28'b0, tag16}, c - 2);
      end
      if (c < 8) begin
        chk($sformatf("stream_in_ready_c%0d", c), {31'b0, ir16}, 32'd1);
        tagR = 4'(c);
        vld16 = 1'b1;
      end else begin
        vld16 = 1'b0;
      end
    end
    @(negedge clk);
    chk("stream_drained", {31'b0, ov16}, 32'd0);

    // Backpressure: out_ready low for 5 cycles while offering tags 1,2,3
    outRdy = 1'b0;
    aR = 32'h0003; bR = 32'h0007; opR = SLT;
    tagR = 4'd1; vld16 = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_c1", {31'b0, ir16}, 32'd1);
    tagR = 4'd2;
    @(negedge clk);
    tagR = 4'd3;
    for (int c = 2; c < 5; c++) begin
      chk($sformatf("bp_in_ready_c%0d", c), {31'b0, ir16}, 32'd0);
      chk($sformatf("bp_valid_c%0d", c), {31'b0, ov16}, 32'd1);
      chk($sformatf("bp_tag_c%0d", c), {28'b0, tag16}, 32'd1);
      chk($sformatf("bp_flag_c%0d", c), {31'b0, fl16}, 32'd1);
      @(negedge clk);
    end
    outRdy = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'b0, ir16}, 32'd1);
    chk("bp_out_tag1", {28'b0, tag16}, 32'd1);
    @(negedge clk);
    vld16 = 1'b0;
    chk("bp_out_valid2", {31'b0, ov16}, 32'd1);
    chk("bp_out_tag2", {28'b0, tag16}, 32'd2);
    @(negedge clk);
    chk("bp_out_valid3", {31'b0, ov16}, 32'd1);
    chk("bp_out_tag3", {28'b0, tag16}, 32'd3);
    @(negedge clk);
    chk("bp_no_dup", {31'b0, ov16}, 32'd0);

    // Asynchronous reset with two ops in flight
    opR = SLE; aR = 32'h0004; bR = 32'h0004;
    tagR = 4'd5; vld16 = 1'b1;
    @(negedge clk);
    tagR = 4'd6;
    @(negedge clk);
    vld16 = 1'b0;
    outRdy = 1'b0;
    chk("inflight_valid", {31'b0, ov16}, 32'd1);
    chk("inflight_result", {16'b0, res16}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, ov16}, 32'd0);
    chk("arst_out_result", {16'b0, res16}, 32'd0);
    chk("arst_out_tag", {28'b0, tag16}, 32'd0);
    chk("arst_in_ready", {31'b0, ir16}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    outRdy = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", {31'b0, ov16}, 32'd0);
    runVec(16, SLT, 1'b0, 32'h0001, 32'h0002, 1'b1, 4'd9, "post_rst_slt");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
